// File: rtl/mult_div_if.sv
// Execute-stage bus between the pipeline and the multiply/divide unit.
interface mult_div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, srca, srcb, mthi, mtlo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// mult/multu: shift-add; div/divu: restoring, one bit per cycle.
// Signed ops run on magnitudes and fix signs in a final cycle.
module mult_div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 6
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave md
);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            b_zero_q, b_zero_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_step;
  logic [XLEN:0]   div_shift, div_diff;
  logic [PW-1:0]   div_step;
  logic            res_neg;
  logic [PW-1:0]   prod_signed;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] fix_hi, fix_lo;

  // Operand magnitudes at launch; unsigned ops pass operands through
  always_comb begin
    a_neg = ~md.op[0] & md.srca[XLEN-1];
    b_neg = ~md.op[0] & md.srcb[XLEN-1];
    a_mag = a_neg ? -md.srca : md.srca;
    b_mag = b_neg ? -md.srcb : md.srcb;
  end

  // One iteration step for each operation plus the final sign correction
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = prod_q[PW-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    res_neg     = sign_a_q ^ sign_b_q;
    prod_signed = res_neg ? -prod_q : prod_q;
    quo         = prod_q[XLEN-1:0];
    rem         = prod_q[PW-1:XLEN];
    // Divide by zero leaves an all-ones quotient magnitude; force it unsigned
    fix_lo = is_div_q ? (b_zero_q ? '1 : (res_neg ? -quo : quo))
                      : prod_signed[XLEN-1:0];
    fix_hi = is_div_q ? (sign_a_q ? -rem : rem)
                      : prod_signed[PW-1:XLEN];
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          is_div_d = md.op[1];
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          b_zero_d = (md.srcb == '0);
          opnd_d   = md.op[1] ? b_mag : a_mag;
          prod_d   = {{XLEN{1'b0}}, (md.op[1] ? a_mag : b_mag)};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          if (md.mthi) hi_d = md.wd;
          if (md.mtlo) lo_d = md.wd;
        end
      end
      S_RUN: begin
        prod_d = is_div_q ? div_step : mul_step;
        cnt_d  = cnt_q + CNTW'(1);
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mult_div_if #(.XLEN(XLEN)) md_bus ();

  mult_div_unit #(.XLEN(XLEN), .CNTW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Reference: MIPS HI/LO semantics from plain integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin
        sp = longint'(sa) * longint'(sb);
        {mhi, mlo} = 64'(sp);
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = up;
      end
      2'd2: begin
        if (b == 32'h0) begin
          mhi = a; mlo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          mhi = 32'h0; mlo = 32'h8000_0000;
        end else begin
          mlo = 32'(sa / sb);
          mhi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'h0) begin
          mhi = a; mlo = 32'hFFFF_FFFF;
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    md_bus.start = 1'b0;
    md_bus.op    = 2'd0;
    md_bus.srca  = '0;
    md_bus.srcb  = '0;
    md_bus.mthi  = 1'b0;
    md_bus.mtlo  = 1'b0;
    md_bus.wd    = '0;
  endtask

  // Present start for one edge
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_bus.start = 1'b1;
    md_bus.op    = op;
    md_bus.srca  = a;
    md_bus.srcb  = b;
    tick();
    md_bus.start = 1'b0;
  endtask

  // Launch one op and follow it to completion (bounded)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output logic done_seen,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic done_next);
    launch(op, a, b);
    busy_cyc = 0;
    while (md_bus.busy === 1'b1 && busy_cyc < 60) begin
      busy_cyc++;
      tick();
    end
    done_seen = md_bus.done;
    rhi       = md_bus.hi;
    rlo       = md_bus.lo;
    tick();
    done_next = md_bus.done;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    n_vec += 4;
    if (md_bus.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", md_bus.busy); end
    if (md_bus.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", md_bus.done); end
    if (md_bus.hi !== 32'h0) begin n_err++; $display("FAIL reset hi: got %h expected 0", md_bus.hi); end
    if (md_bus.lo !== 32'h0) begin n_err++; $display("FAIL reset lo: got %h expected 0", md_bus.lo); end
  endtask

  task automatic test_mthi_mtlo();
    md_bus.mthi = 1'b1; md_bus.wd = 32'hAAAA_0001;
    tick();
    md_bus.mthi = 1'b0;
    n_vec += 2;
    if (md_bus.hi !== 32'hAAAA_0001) begin n_err++; $display("FAIL mthi hi: got %h expected aaaa0001", md_bus.hi); end
    if (md_bus.lo !== 32'h0) begin n_err++; $display("FAIL mthi lo: got %h expected 0", md_bus.lo); end
    md_bus.mtlo = 1'b1; md_bus.wd = 32'h5555_0002;
    tick();
    md_bus.mtlo = 1'b0;
    n_vec += 3;
    if (md_bus.hi !== 32'hAAAA_0001) begin n_err++; $display("FAIL mtlo hi: got %h expected aaaa0001", md_bus.hi); end
    if (md_bus.lo !== 32'h5555_0002) begin n_err++; $display("FAIL mtlo lo: got %h expected 55550002", md_bus.lo); end
    if (md_bus.done !== 1'b0) begin n_err++; $display("FAIL mtlo done: got %b expected 0", md_bus.done); end
  endtask

  task automatic test_directed();
    vec_t        dir [8];
    int          bc;
    logic        ds, dn;
    logic [31:0] rh, rl;
    dir[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    dir[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    dir[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dir[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    dir[4] = '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    dir[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    dir[6] = '{2'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    dir[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(dir[i].op, dir[i].a, dir[i].b, bc, ds, rh, rl, dn);
      n_vec += 5;
      if (bc !== 33) begin n_err++; $display("FAIL directed[%0d] busy cycles: got %0d expected 33", i, bc); end
      if (ds !== 1'b1) begin n_err++; $display("FAIL directed[%0d] done: got %b expected 1", i, ds); end
      if (rh !== dir[i].hi) begin n_err++; $display("FAIL directed[%0d] hi: got %h expected %h", i, rh, dir[i].hi); end
      if (rl !== dir[i].lo) begin n_err++; $display("FAIL directed[%0d] lo: got %h expected %h", i, rl, dir[i].lo); end
      if (dn !== 1'b0) begin n_err++; $display("FAIL directed[%0d] done width: got %b expected 0", i, dn); end
    end
  endtask

  task automatic test_random();
    int          bc;
    logic        ds, dn;
    logic [31:0] rh, rl, eh, el, a, b;
    logic [1:0]  op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, eh, el);
      run_op(op, a, b, bc, ds, rh, rl, dn);
      n_vec += 3;
      if (bc !== 33) begin n_err++; $display("FAIL random[%0d] busy cycles: got %0d expected 33", i, bc); end
      if (rh !== eh) begin n_err++; $display("FAIL random[%0d] op%0d %h,%h hi: got %h expected %h", i, op, a, b, rh, eh); end
      if (rl !== el) begin n_err++; $display("FAIL random[%0d] op%0d %h,%h lo: got %h expected %h", i, op, a, b, rl, el); end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    int dones;
    md_bus.mthi = 1'b1; md_bus.wd = 32'hAAAA_0001;
    tick();
    md_bus.mthi = 1'b0;
    md_bus.mtlo = 1'b1; md_bus.wd = 32'h5555_0002;
    tick();
    md_bus.mtlo = 1'b0;
    // start wins over a simultaneous mthi
    md_bus.mthi = 1'b1; md_bus.wd = 32'hDEAD_BEEF;
    launch(2'd1, 32'd6, 32'd7);
    md_bus.mthi = 1'b0;
    n_vec += 2;
    if (md_bus.busy !== 1'b1) begin n_err++; $display("FAIL ignore busy after start: got %b expected 1", md_bus.busy); end
    if (md_bus.hi !== 32'hAAAA_0001) begin n_err++; $display("FAIL ignore start priority hi: got %h expected aaaa0001", md_bus.hi); end
    cyc = 0;
    while (md_bus.busy === 1'b1 && cyc < 60) begin
      if (cyc == 10) begin
        md_bus.start = 1'b1; md_bus.op = 2'd1; md_bus.srca = 32'd2; md_bus.srcb = 32'd3;
        md_bus.mthi = 1'b1; md_bus.mtlo = 1'b1; md_bus.wd = 32'hDEAD_BEEF;
      end else begin
        md_bus.start = 1'b0; md_bus.mthi = 1'b0; md_bus.mtlo = 1'b0;
      end
      if (cyc == 20) begin
        n_vec += 2;
        if (md_bus.hi !== 32'hAAAA_0001) begin n_err++; $display("FAIL ignore hold hi: got %h expected aaaa0001", md_bus.hi); end
        if (md_bus.lo !== 32'h5555_0002) begin n_err++; $display("FAIL ignore hold lo: got %h expected 55550002", md_bus.lo); end
      end
      cyc++;
      tick();
    end
    idle_inputs();
    n_vec += 4;
    if (cyc !== 33) begin n_err++; $display("FAIL ignore busy cycles: got %0d expected 33", cyc); end
    if (md_bus.done !== 1'b1) begin n_err++; $display("FAIL ignore done: got %b expected 1", md_bus.done); end
    if (md_bus.hi !== 32'h0) begin n_err++; $display("FAIL ignore hi: got %h expected 0", md_bus.hi); end
    if (md_bus.lo !== 32'd42) begin n_err++; $display("FAIL ignore lo: got %h expected 2a", md_bus.lo); end
    tick();
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_bus.done === 1'b1 || md_bus.busy === 1'b1) dones++;
      tick();
    end
    n_vec++;
    if (dones !== 0) begin n_err++; $display("FAIL ignore second op: got %0d busy/done cycles expected 0", dones); end
    md_bus.mthi = 1'b1; md_bus.mtlo = 1'b1; md_bus.wd = 32'h1234;
    tick();
    idle_inputs();
    n_vec += 2;
    if (md_bus.hi !== 32'h1234) begin n_err++; $display("FAIL both mthi/mtlo hi: got %h expected 1234", md_bus.hi); end
    if (md_bus.lo !== 32'h1234) begin n_err++; $display("FAIL both mthi/mtlo lo: got %h expected 1234", md_bus.lo); end
  endtask

  task automatic test_reset_mid();
    int          bc;
    logic        ds, dn;
    logic [31:0] rh, rl;
    launch(2'd0, $urandom, $urandom);
    repeat (15) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec += 4;
    if (md_bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset busy: got %b expected 0", md_bus.busy); end
    if (md_bus.done !== 1'b0) begin n_err++; $display("FAIL midreset done: got %b expected 0", md_bus.done); end
    if (md_bus.hi !== 32'h0) begin n_err++; $display("FAIL midreset hi: got %h expected 0", md_bus.hi); end
    if (md_bus.lo !== 32'h0) begin n_err++; $display("FAIL midreset lo: got %h expected 0", md_bus.lo); end
    run_op(2'd3, 32'd100, 32'd7, bc, ds, rh, rl, dn);
    n_vec += 4;
    if (bc !== 33) begin n_err++; $display("FAIL midreset rerun busy cycles: got %0d expected 33", bc); end
    if (ds !== 1'b1) begin n_err++; $display("FAIL midreset rerun done: got %b expected 1", ds); end
    if (rh !== 32'd2) begin n_err++; $display("FAIL midreset rerun hi: got %h expected 2", rh); end
    if (rl !== 32'd14) begin n_err++; $display("FAIL midreset rerun lo: got %h expected e", rl); end
  endtask

  task automatic test_back_to_back();
    int          c, gap;
    logic [1:0]  op1, op2;
    logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
    for (int k = 0; k < 3; k++) begin
      op1 = 2'($urandom_range(0, 3)); a1 = pick_operand(); b1 = pick_operand();
      op2 = 2'($urandom_range(0, 3)); a2 = pick_operand(); b2 = pick_operand();
      model(op1, a1, b1, eh1, el1);
      model(op2, a2, b2, eh2, el2);
      launch(op1, a1, b1);
      c = 0;
      while (md_bus.done !== 1'b1 && c < 60) begin
        c++;
        tick();
      end
      n_vec += 3;
      if (md_bus.done !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] first done: timeout after %0d cycles", k, c); end
      if (md_bus.hi !== eh1) begin n_err++; $display("FAIL b2b[%0d] first hi: got %h expected %h", k, md_bus.hi, eh1); end
      if (md_bus.lo !== el1) begin n_err++; $display("FAIL b2b[%0d] first lo: got %h expected %h", k, md_bus.lo, el1); end
      // Issue the next op in the done cycle
      md_bus.start = 1'b1; md_bus.op = op2; md_bus.srca = a2; md_bus.srcb = b2;
      tick();
      md_bus.start = 1'b0;
      gap = 1;
      while (md_bus.done !== 1'b1 && gap < 80) begin
        tick();
        gap++;
      end
      n_vec += 3;
      if (gap !== 34) begin n_err++; $display("FAIL b2b[%0d] done spacing: got %0d expected 34", k, gap); end
      if (md_bus.hi !== eh2) begin n_err++; $display("FAIL b2b[%0d] second hi: got %h expected %h", k, md_bus.hi, eh2); end
      if (md_bus.lo !== el2) begin n_err++; $display("FAIL b2b[%0d] second lo: got %h expected %h", k, md_bus.lo, el2); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core; sits in the execute stage beside the ALU.
- Owns the HI/LO architectural registers.
- Consumes mult, multu, div, divu, mthi and mtlo.
- Its hi/lo outputs feed the writeback mux ahead of the register file (mfhi/mflo), and busy drives the hazard unit's stall logic.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- start  input  1  launch operation when idle.
- op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- srca  input  XLEN  rs operand (multiplicand / dividend).
- srcb  input  XLEN  rt operand (multiplier / divisor).
- mthi  input  1  write wd into HI when idle.
- mtlo  input  1  write wd into LO when idle.
- wd  input  XLEN  mthi/mtlo data.
- busy  output  1  operation in progress; hazard unit stalls on mfhi/mflo/mult/div.
- done  output  1  one-cycle pulse: HI/LO updated this cycle.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (reset==0 at posedge):
  - Next state is IDLE; counter=0.
  - busy=0, done=0, hi=0, lo=0.
  - Overrides any operation in flight, and any start or mthi/mtlo in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1 at edge E0: latch op. For signed ops, latch abs(srca) and abs(srcb) plus their sign bits; for unsigned ops, latch the raw operands. Clear the accumulator and counter, go to RUN, busy=1.
  - If start=0: mthi writes hi<=wd and mtlo writes lo<=wd at the edge. Both may be asserted together; both then take wd.
  - start has priority over mthi/mtlo in the same cycle; the mthi/mtlo write is dropped.
- RUN: exactly 32 edges (E1..E32), counter 0..31, one iteration per edge.
  - Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - Divide: restoring, one quotient bit per edge; 33-bit trial subtract.
  - When counter==31 the next state is FIX.
- FIX (edge E33):
  - Apply sign correction and write hi/lo.
  - done=1 for the cycle after E33; busy=0 that same cycle; state returns to IDLE.
- Latency: start sampled at E0 → hi/lo valid and done=1 after E33. busy is 1 for exactly 33 cycles.
- Multiply results:
  - hi:lo = full 64-bit product.
  - mult is signed: negate the 64-bit magnitude if the sign bits differ.
  - multu is unsigned.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder.
  - div: quotient negative iff signs differ; remainder takes the dividend's sign.
- Divide by zero (srcb==0): no trap, same 33-cycle latency.
  - divu: lo=32'hFFFFFFFF, hi=srca.
  - div: lo=32'hFFFFFFFF, hi=srca (original signed value).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag. abs(0x80000000) is treated as unsigned 0x80000000.
- Inputs ignored while busy: start, op, srca, srcb, mthi, mtlo. hi/lo hold their old values until FIX.
- start in the cycle where done=1: accepted, because the state is IDLE. A back-to-back operation gives done pulses 34 edges apart.
- hi/lo change only on reset, FIX, or an idle mthi/mtlo.

Test Plan:
- Reset, then multu with srca=srcb=0xFFFFFFFF:
  - busy=1 for 33 cycles, then done=1 for one cycle.
  - hi=0xFFFFFFFE, lo=0x00000001.
- mult with srca=0xFFFFFFFD (-3), srcb=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divides:
  - div with srca=0xFFFFFFF9 (-7), srcb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu with srca=100, srcb=7 → lo=14, hi=2.
- Divide by zero and overflow:
  - divu with srca=100, srcb=0 → lo=0xFFFFFFFF, hi=100 after 33 cycles.
  - div with srca=0x80000000, srcb=0xFFFFFFFF → lo=0x80000000, hi=0.
- Ignored inputs while busy:
  - Pulse start (multu 2*3) and mthi (wd=0xDEADBEEF) at cycle 10 of a multu 6*7 → result hi=0, lo=42.
  - No second done pulse.
  - Afterwards, mthi+mtlo with wd=0x1234 while idle → hi=lo=0x1234 next cycle.
- Reset mid-operation:
  - Drive reset=0 at RUN cycle 15 → next cycle busy=0, done=0, hi=lo=0.
  - A new start is then accepted and completes normally.
